chirp_waveform_responder: RTL and testbench



---
 rtl/chirp_waveform_responder.sv | 179 +++++++++++++++++
 tb/tb_chirp_waveform_responder.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/chirp_waveform_responder.sv
// -----------------------------------------------------------------------------
// chirp_waveform_responder
//
// Purpose:
//   Target side of the chirp handshake in the FMC150 (DAC) clock domain.
//   Advertises readiness, accepts a chirp_init pulse qualified by chirp_enable,
//   latches the chirp parameter word, then streams a quadratic-phase (linear-FM)
//   phase word to the DAC DDS. Reports chirp_active while running and pulses
//   chirp_done once per completed chirp, or chirp_abort when the DAC path
//   drops out mid-chirp.
//
// Ports:
//   i_clk_fmc150            DAC-domain clock (245.76 MHz)
//   i_resetn_fmc150         asynchronous active-low reset
//   i_dac_ready             level, DAC path locked/calibrated
//   i_chirp_parameters_in   [31:0] counter_max, [63:32] tuning_coef,
//                           [95:64] freq_offset, [127:96] unused
//   i_chirp_init            single-cycle start request
//   i_chirp_enable          level, controller permits chirping
//   o_chirp_ready           high in READY while dac_ready is high
//   o_chirp_active          high on every sample cycle of a chirp
//   o_chirp_done            one-cycle pulse after the last sample
//   o_chirp_abort           one-cycle pulse when dac_ready is lost mid-chirp
//   o_dds_phase             top PHASE_OUT_WIDTH bits of the phase accumulator
//   o_dds_phase_valid       qualifies o_dds_phase (same as o_chirp_active)
// -----------------------------------------------------------------------------
module chirp_waveform_responder #(
  parameter int PHASE_OUT_WIDTH = 16,
  parameter int HOLDOFF_CYCLES  = 4
) (
  input  logic                       i_clk_fmc150,
  input  logic                       i_resetn_fmc150,
  input  logic                       i_dac_ready,
  input  logic [127:0]               i_chirp_parameters_in,
  input  logic                       i_chirp_init,
  input  logic                       i_chirp_enable,
  output logic                       o_chirp_ready,
  output logic                       o_chirp_active,
  output logic                       o_chirp_done,
  output logic                       o_chirp_abort,
  output logic [PHASE_OUT_WIDTH-1:0] o_dds_phase,
  output logic                       o_dds_phase_valid
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READY = 2'd1,
    S_CHIRP = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_chirp_ready;
  logic        r_chirp_active;
  logic        r_chirp_done;
  logic        r_chirp_abort;

  logic        w_ready_nxt;
  logic        w_active_nxt;
  logic        w_done_nxt;
  logic        w_abort_nxt;

  // Shadow copies of the parameter word, frozen for the duration of a chirp.
  logic [31:0] r_cnt_max_s;
  logic [31:0] r_tune_s;
  logic [31:0] r_offs_s;

  logic [31:0] r_freq_acc;
  logic [31:0] r_phase_acc;
  logic [31:0] r_n;
  logic [31:0] r_hold;

  logic        w_start;
  logic        w_last;
  logic        w_hold_end;
  logic        w_advance;
  logic        w_unused_bits;

  // Loss of dac_ready takes priority over a coincident start request.
  assign w_start    = (r_state == S_READY) & i_dac_ready & i_chirp_init & i_chirp_enable;
  // Full 32-bit equality so counter_max = 0xFFFFFFFF never wraps early.
  assign w_last     = (r_n == r_cnt_max_s);
  assign w_hold_end = (r_hold == 32'(HOLDOFF_CYCLES));
  // Accumulators step only between samples; on the last sample they hold,
  // which keeps the final phase on the output after the chirp ends.
  assign w_advance  = (r_state == S_CHIRP) & i_dac_ready & ~w_last;

  assign w_unused_bits = ^{i_chirp_parameters_in[127:96], r_phase_acc};

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    w_abort_nxt = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_dac_ready) w_state_nxt = S_READY;
      end
      S_READY: begin
        if (!i_dac_ready)  w_state_nxt = S_IDLE;
        else if (w_start)  w_state_nxt = S_CHIRP;
      end
      S_CHIRP: begin
        if (!i_dac_ready) begin
          w_state_nxt = S_IDLE;
          w_abort_nxt = 1'b1;
        end else if (w_last) begin
          w_state_nxt = S_DONE;
          w_done_nxt  = 1'b1;
        end
      end
      S_DONE: begin
        if (w_hold_end) w_state_nxt = i_dac_ready ? S_READY : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Status outputs are registered from the next state so they line up
    // with the state they describe.
    w_ready_nxt  = (w_state_nxt == S_READY);
    w_active_nxt = (w_state_nxt == S_CHIRP);
  end

  // State and status registers
  always_ff @(posedge i_clk_fmc150 or negedge i_resetn_fmc150) begin
    if (!i_resetn_fmc150) begin
      r_state        <= S_IDLE;
      r_chirp_ready  <= 1'b0;
      r_chirp_active <= 1'b0;
      r_chirp_done   <= 1'b0;
      r_chirp_abort  <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_chirp_ready  <= w_ready_nxt;
      r_chirp_active <= w_active_nxt;
      r_chirp_done   <= w_done_nxt;
      r_chirp_abort  <= w_abort_nxt;
    end
  end

  // Parameter latch, phase/frequency accumulators, sample and holdoff counters
  always_ff @(posedge i_clk_fmc150 or negedge i_resetn_fmc150) begin
    if (!i_resetn_fmc150) begin
      r_cnt_max_s <= 32'd0;
      r_tune_s    <= 32'd0;
      r_offs_s    <= 32'd0;
      r_freq_acc  <= 32'd0;
      r_phase_acc <= 32'd0;
      r_n         <= 32'd0;
      r_hold      <= 32'd0;
    end else begin
      if (w_start) begin
        r_cnt_max_s <= i_chirp_parameters_in[31:0];
        r_tune_s    <= i_chirp_parameters_in[63:32];
        r_offs_s    <= i_chirp_parameters_in[95:64];
        r_freq_acc  <= i_chirp_parameters_in[95:64];
        r_phase_acc <= 32'd0;
        r_n         <= 32'd0;
      end else if (w_advance) begin
        r_phase_acc <= r_phase_acc + r_freq_acc;
        r_freq_acc  <= r_freq_acc + r_tune_s;
        r_n         <= r_n + 32'd1;
      end

      // Counts cycles spent in DONE; the done-pulse cycle is count 0.
      if (r_state == S_DONE) r_hold <= r_hold + 32'd1;
      else                   r_hold <= 32'd0;
    end
  end

  assign o_chirp_ready     = r_chirp_ready;
  assign o_chirp_active    = r_chirp_active;
  assign o_chirp_done      = r_chirp_done;
  assign o_chirp_abort     = r_chirp_abort;
  assign o_dds_phase_valid = r_chirp_active;
  assign o_dds_phase       = r_phase_acc[31 -: PHASE_OUT_WIDTH];

endmodule

// File: tb/tb_chirp_waveform_responder.sv
// -----------------------------------------------------------------------------
// tb_chirp_waveform_responder
//
// Self-checking bench: a behavioural model computes the expected outputs from
// the handshake rules and the closed-form chirp phase
//   phase(k) = k*offs + tune*k*(k-1)/2  (mod 2^32)
// and a compare process checks every cycle. Directed sequences pin literal
// values, then randomized chirps exercise the handshake and phase arithmetic.
// -----------------------------------------------------------------------------
module tb_chirp_waveform_responder;

  localparam int W = 16;
  localparam int H = 4;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         dac   = 1'b0;
  logic         init  = 1'b0;
  logic         en    = 1'b0;
  logic [127:0] params = '0;

  logic         ready, active, done, abort, valid;
  logic [W-1:0] phase;

  int n_tests = 0;
  int n_fail  = 0;

  chirp_waveform_responder #(
    .PHASE_OUT_WIDTH(W),
    .HOLDOFF_CYCLES (H)
  ) dut (
    .i_clk_fmc150         (clk),
    .i_resetn_fmc150      (rst_n),
    .i_dac_ready          (dac),
    .i_chirp_parameters_in(params),
    .i_chirp_init         (init),
    .i_chirp_enable       (en),
    .o_chirp_ready        (ready),
    .o_chirp_active       (active),
    .o_chirp_done         (done),
    .o_chirp_abort        (abort),
    .o_dds_phase          (phase),
    .o_dds_phase_valid    (valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Closed-form chirp phase of sample k.
  function automatic logic [31:0] phase_of(input logic [31:0] k, input logic [31:0] offs,
                                           input logic [31:0] tune);
    logic [63:0] k64;
    logic [63:0] tri64;
    k64   = {32'd0, k};
    tri64 = (k64 * (k64 - 64'd1)) >> 1;
    if (k == 32'd0) tri64 = 64'd0;
    return 32'(k * offs + tri64[31:0] * tune);
  endfunction

  // ---------------- behavioural model ----------------
  int           m_mode = 0;  // 0 idle, 1 ready, 2 chirping, 3 post-chirp holdoff
  logic [31:0]  m_k = 0, m_cnt = 0, m_offs = 0, m_tune = 0, m_hold = 0;
  logic         m_ready = 0, m_active = 0, m_done = 0, m_abort = 0;
  logic [31:0]  m_phase32 = 0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_mode = 0; m_k = 0; m_cnt = 0; m_offs = 0; m_tune = 0; m_hold = 0;
        m_ready = 0; m_active = 0; m_done = 0; m_abort = 0; m_phase32 = 0;
      end else begin
        m_done  = 0;
        m_abort = 0;
        case (m_mode)
          0: if (dac) m_mode = 1;
          1: begin
            if (!dac) m_mode = 0;
            else if (init && en) begin
              m_mode = 2; m_k = 0;
              m_cnt  = params[31:0];
              m_tune = params[63:32];
              m_offs = params[95:64];
            end
          end
          2: begin
            if (!dac) begin m_mode = 0; m_abort = 1; end
            else if (m_k == m_cnt) begin m_mode = 3; m_done = 1; m_hold = 0; end
            else m_k = m_k + 1;
          end
          default: begin
            if (m_hold == H) m_mode = dac ? 1 : 0;
            else m_hold = m_hold + 1;
          end
        endcase
        m_ready  = (m_mode == 1);
        m_active = (m_mode == 2);
        if (m_mode == 2) m_phase32 = phase_of(m_k, m_offs, m_tune);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      chk("cyc_ready",  {31'd0, ready},  {31'd0, m_ready});
      chk("cyc_active", {31'd0, active}, {31'd0, m_active});
      chk("cyc_valid",  {31'd0, valid},  {31'd0, m_active});
      chk("cyc_done",   {31'd0, done},   {31'd0, m_done});
      chk("cyc_abort",  {31'd0, abort},  {31'd0, m_abort});
      chk("cyc_phase",  {16'd0, phase},  {16'd0, m_phase32[31:16]});
    end
  end

  // ---------------- stimulus ----------------
  task automatic start_chirp(input logic [31:0] offs, input logic [31:0] tune,
                             input logic [31:0] cnt);
    params = {32'hDEAD_BEEF, offs, tune, cnt};
    init = 1'b1; en = 1'b1;
    @(negedge clk);
    init = 1'b0;
  endtask

  task automatic wait_ready(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (ready) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    chk("wait_ready", {31'd0, seen}, 32'd1);
  endtask

  initial begin
    logic [15:0] basic_ph [4];
    logic [15:0] wrap_ph  [3];
    int nv;
    basic_ph = '{16'h0000, 16'h0001, 16'h0002, 16'h0003};
    wrap_ph  = '{16'h0000, 16'hFFFF, 16'hFFFF};

    chk("model_pin_basic", phase_of(32'd3, 32'h0001_0000, 32'd1), 32'h0003_0003);
    chk("model_pin_wrap",  phase_of(32'd2, 32'hFFFF_0000, 32'h0001_0000), 32'hFFFF_0000);

    // Reset state
    dac = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready",  {31'd0, ready},  32'd0);
    chk("rst_active", {31'd0, active}, 32'd0);
    chk("rst_done",   {31'd0, done},   32'd0);
    chk("rst_abort",  {31'd0, abort},  32'd0);
    chk("rst_valid",  {31'd0, valid},  32'd0);
    chk("rst_phase",  {16'd0, phase},  32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("ready_after_reset", {31'd0, ready}, 32'd1);

    // Basic chirp with literal phases and timing
    start_chirp(32'h0001_0000, 32'h0000_0001, 32'd3);
    for (int k = 0; k < 4; k++) begin
      chk("basic_active", {31'd0, active}, 32'd1);
      chk("basic_phase",  {16'd0, phase},  {16'd0, basic_ph[k]});
      @(negedge clk);
    end
    chk("basic_done",        {31'd0, done},   32'd1);
    chk("basic_active_off",  {31'd0, active}, 32'd0);
    chk("basic_phase_hold",  {16'd0, phase},  32'h0000_0003);
    for (int i = 6; i <= 9; i++) begin
      @(negedge clk);
      chk("basic_holdoff_ready", {31'd0, ready}, 32'd0);
    end
    @(negedge clk);
    chk("basic_ready_back", {31'd0, ready}, 32'd1);

    // Wrap-around chirp
    start_chirp(32'hFFFF_0000, 32'h0001_0000, 32'd2);
    for (int k = 0; k < 3; k++) begin
      chk("wrap_phase", {16'd0, phase}, {16'd0, wrap_ph[k]});
      @(negedge clk);
    end
    chk("wrap_done", {31'd0, done}, 32'd1);
    wait_ready(20);

    // Single-sample chirp
    start_chirp(32'h1234_5678, 32'h9ABC_DEF0, 32'd0);
    chk("one_active", {31'd0, active}, 32'd1);
    chk("one_phase",  {16'd0, phase},  32'd0);
    @(negedge clk);
    chk("one_done",   {31'd0, done},   32'd1);
    chk("one_active_off", {31'd0, active}, 32'd0);
    wait_ready(20);

    // Init without enable is ignored
    params = {32'd0, 32'h0000_1000, 32'd5, 32'd4};
    init = 1'b1; en = 1'b0;
    @(negedge clk);
    init = 1'b0;
    chk("noen_active", {31'd0, active}, 32'd0);
    chk("noen_ready",  {31'd0, ready},  32'd1);

    // Second init, parameter change and enable drop mid-chirp are ignored
    start_chirp(32'h1234_5678, 32'h00AB_CDEF, 32'd8);
    nv = valid ? 1 : 0;
    for (int i = 0; i < 30; i++) begin
      if (i == 2) begin
        init = 1'b1; en = 1'b1;
        params = {$urandom, $urandom, $urandom, 32'd50};
      end else begin
        init = 1'b0;
      end
      if (i == 4) en = 1'b0;
      @(negedge clk);
      nv += valid ? 1 : 0;
    end
    chk("reinit_sample_count", nv, 32'd9);
    wait_ready(20);

    // Abort: dac_ready dropped at sample 5
    start_chirp($urandom, $urandom, 32'd100);
    repeat (5) @(negedge clk);
    dac = 1'b0;
    @(negedge clk);
    chk("abort_pulse",  {31'd0, abort},  32'd1);
    chk("abort_active", {31'd0, active}, 32'd0);
    chk("abort_done",   {31'd0, done},   32'd0);
    chk("abort_ready",  {31'd0, ready},  32'd0);
    @(negedge clk);
    chk("abort_single", {31'd0, abort},  32'd0);
    dac = 1'b1;
    @(negedge clk);
    chk("abort_ready_back", {31'd0, ready}, 32'd1);

    // Reset mid-chirp
    start_chirp(32'h0100_0000, 32'h0000_0100, 32'd20);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_active", {31'd0, active}, 32'd0);
    chk("midrst_phase",  {16'd0, phase},  32'd0);
    chk("midrst_done",   {31'd0, done},   32'd0);
    chk("midrst_abort",  {31'd0, abort},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready(10);

    // Randomized chirps
    for (int it = 0; it < 40; it++) begin
      dac = 1'b1;
      wait_ready(40);
      params = {$urandom, $urandom, $urandom, 32'($urandom_range(0, 20))};
      init = 1'b1;
      en = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      init = 1'b0;
      for (int c = 0; c < 30; c++) begin
        init = ($urandom_range(0, 6) == 0);
        en   = ($urandom_range(0, 1) == 0);
        if ($urandom_range(0, 3) == 0) params = {$urandom, $urandom, $urandom, 32'($urandom_range(0, 20))};
        dac  = ($urandom_range(0, 59) != 0);
        @(negedge clk);
      end
      init = 1'b0;
    end
    dac = 1'b1;
    repeat (12) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
